sr_excitation_driver: RTL and testbench

//  Inverse of an SR flip-flop bank: accepts a target word via valid/ready and drives
//  per-bit S/R excitation into WIDTH external SR flip-flops sharing Clock.

---
 rtl/sr_excitation_driver.sv | 141 ++++++++++++++
 tb/tb_sr_excitation_driver.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver
// Loads a bank of external SR flip-flops to a requested word. For every bit
// it drives S or R only where the flop disagrees with the target. It then
// reads Q back and re-drives on a mismatch. It reports Done, or Error once
// the retry budget is used up.
module sr_excitation_driver #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_RETRY     = 3
) (
   input  logic                              Clock,
   input  logic                              Reset,
   input  logic                              TargetValid,
   output logic                              TargetReady,
   input  logic [WIDTH-1:0]                  Target,
   input  logic [WIDTH-1:0]                  QFeedback,
   output logic [WIDTH-1:0]                  S,
   output logic [WIDTH-1:0]                  R,
   output logic                              Done,
   output logic                              Error,
   output logic [$clog2(MAX_RETRY+2)-1:0]    Attempts
);

   localparam int AW = $clog2(MAX_RETRY + 2);
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [AW-1:0] LAST_ATTEMPT = AW'(MAX_RETRY + 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WIDTH-1:0]  target_reg;
   logic [WIDTH-1:0]  target_next;
   logic [WIDTH-1:0]  s_next;
   logic [WIDTH-1:0]  r_next;
   logic              done_next;
   logic              error_next;
   logic [AW-1:0]     attempts_next;
   logic [CW-1:0]     settle_count;
   logic [CW-1:0]     settle_next;
   logic [WIDTH-1:0]  exc_target;
   logic [WIDTH-1:0]  s_exc;
   logic [WIDTH-1:0]  r_exc;

   // Ready only in IDLE, and never while reset is held.
   assign TargetReady = (state == IDLE) && !Reset;

   // Excitation: at accept the incoming word is compared, otherwise the captured one.
   // S and R are disjoint by construction, so no bit is ever both set and reset.
   always_comb begin
      exc_target = (state == IDLE) ? Target : target_reg;
      s_exc      = exc_target & ~QFeedback;
      r_exc      = ~exc_target & QFeedback;
   end

   // Next-state and next-output logic; every pulse output defaults low.
   always_comb begin
      state_next    = state;
      target_next   = target_reg;
      s_next        = '0;
      r_next        = '0;
      done_next     = 1'b0;
      error_next    = 1'b0;
      attempts_next = Attempts;
      settle_next   = settle_count;
      case (state)
         IDLE: begin
            if (TargetValid) begin
               target_next = Target;
               if ((s_exc | r_exc) != '0) begin
                  s_next        = s_exc;
                  r_next        = r_exc;
                  attempts_next = AW'(1);
                  state_next    = DRIVE;
               end else begin
                  attempts_next = '0;
                  done_next     = 1'b1;
               end
            end
         end
         DRIVE: begin
            settle_next = '0;
            state_next  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
         end
         SETTLE: begin
            if (settle_count == SETTLE_LAST) begin
               state_next = CHECK;
            end else begin
               settle_next = settle_count + CW'(1);
            end
         end
         CHECK: begin
            if (QFeedback == target_reg) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end else if (Attempts == LAST_ATTEMPT) begin
               error_next = 1'b1;
               state_next = IDLE;
            end else begin
               s_next        = s_exc;
               r_next        = r_exc;
               attempts_next = Attempts + AW'(1);
               state_next    = DRIVE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops everything immediately.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         target_reg   <= '0;
         S            <= '0;
         R            <= '0;
         Done         <= 1'b0;
         Error        <= 1'b0;
         Attempts     <= '0;
         settle_count <= '0;
      end else begin
         state        <= state_next;
         target_reg   <= target_next;
         S            <= s_next;
         R            <= r_next;
         Done         <= done_next;
         Error        <= error_next;
         Attempts     <= attempts_next;
         settle_count <= settle_next;
      end
   end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb_sr_excitation_driver
// Drives targets into sr_excitation_driver against a model bank of SR flops.
// The bank can have stuck-at-0 bits and bits that ignore their first pulse.
// Expected outcomes are predicted per transaction and checked by a monitor.
module tb_sr_excitation_driver;

   localparam int WIDTH         = 8;
   localparam int SETTLE_CYCLES = 1;
   localparam int MAX_RETRY     = 3;
   localparam int AW            = $clog2(MAX_RETRY + 2);

   logic             Clock;
   logic             Reset;
   logic             TargetValid;
   logic             TargetReady;
   logic [WIDTH-1:0] Target;
   logic [WIDTH-1:0] QFeedback;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic             Done;
   logic             Error;
   logic [AW-1:0]    Attempts;

   typedef struct {
      logic [WIDTH-1:0] target;
      int               att;
      bit               ok;
      logic [WIDTH-1:0] firstS;
      logic [WIDTH-1:0] firstR;
      int               acceptCycle;
   } entry_t;

   entry_t sbQ[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model flop bank state and preset request from the stimulus process.
   logic [WIDTH-1:0] flopQ;
   logic [WIDTH-1:0] stuckMask;
   logic [WIDTH-1:0] ignMask;
   logic             presetReq;
   logic [WIDTH-1:0] presetQ;
   logic [WIDTH-1:0] presetStuck;
   logic [WIDTH-1:0] presetIgn;

   sr_excitation_driver #(
      .WIDTH(WIDTH),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MAX_RETRY(MAX_RETRY)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .TargetValid(TargetValid),
      .TargetReady(TargetReady),
      .Target(Target),
      .QFeedback(QFeedback),
      .S(S),
      .R(R),
      .Done(Done),
      .Error(Error),
      .Attempts(Attempts)
   );

   assign QFeedback = flopQ;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Cycle counter used for latency checks.
   always @(posedge Clock) cyc <= cyc + 1;

   // External SR flop bank sharing Clock, with fault injection.
   always @(posedge Clock) begin
      if (presetReq) begin
         flopQ     <= presetQ & ~presetStuck;
         stuckMask <= presetStuck;
         ignMask   <= presetIgn;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (stuckMask[i]) begin
               flopQ[i] <= 1'b0;
            end else if ((S[i] | R[i]) && ignMask[i]) begin
               ignMask[i] <= 1'b0;
            end else if (S[i]) begin
               flopQ[i] <= 1'b1;
            end else if (R[i]) begin
               flopQ[i] <= 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Outcome of loading tgt: each attempt fixes every disagreeing bit
   // except stuck ones and those still swallowing their first pulse.
   function automatic void predict(input logic [WIDTH-1:0] q0, input logic [WIDTH-1:0] tgt,
                                   input logic [WIDTH-1:0] stuck, input logic [WIDTH-1:0] ign,
                                   output int att, output bit ok);
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] ig;
      logic [WIDTH-1:0] need;
      logic [WIDTH-1:0] chg;
      q   = q0 & ~stuck;
      ig  = ign;
      att = 0;
      ok  = 1'b1;
      if (q == tgt) return;
      ok = 1'b0;
      for (int a = 1; a <= MAX_RETRY + 1; a++) begin
         need = q ^ tgt;
         chg  = need & ~stuck & ~ig;
         ig   = ig & ~need;
         q    = (q & ~chg) | (tgt & chg);
         att  = a;
         if (q == tgt) begin
            ok = 1'b1;
            return;
         end
      end
   endfunction

   // Load the model flop bank while the DUT is idle.
   task automatic setFlops(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] stuck,
                           input logic [WIDTH-1:0] ign);
      @(negedge Clock);
      presetQ     = q;
      presetStuck = stuck;
      presetIgn   = ign;
      presetReq   = 1'b1;
      @(posedge Clock);
      #1 presetReq = 1'b0;
   endtask

   // Wait for ready (scribbling on the inputs while busy), then offer tgt.
   task automatic applyStimulus(input logic [WIDTH-1:0] tgt);
      entry_t e;
      bit     ready;
      ready = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge Clock);
         if (TargetReady) begin
            ready = 1'b1;
            break;
         end
         TargetValid = 1'($urandom);
         Target      = WIDTH'($urandom);
      end
      if (!ready) begin
         checkOutput("ready_timeout", 0, 1);
      end else begin
         predict(flopQ, tgt, stuckMask, ignMask, e.att, e.ok);
         e.target      = tgt;
         e.firstS      = tgt & ~flopQ;
         e.firstR      = ~tgt & flopQ;
         e.acceptCycle = cyc + 1;
         sbQ.push_back(e);
         TargetValid = 1'b1;
         Target      = tgt;
         @(posedge Clock);
         #1;
         TargetValid = 1'b0;
         Target      = WIDTH'($urandom);
      end
   endtask

   // Wait until every issued transaction has completed.
   task automatic drain();
      bit empty;
      empty = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge Clock);
         if (!TargetReady) begin
            TargetValid = 1'($urandom);
            Target      = WIDTH'($urandom);
         end else begin
            TargetValid = 1'b0;
         end
         if (sbQ.size() == 0 && TargetReady) begin
            empty = 1'b1;
            break;
         end
      end
      if (!empty) checkOutput("drain_timeout", sbQ.size(), 0);
   endtask

   // Monitor: checks every drive pulse and pops the scoreboard on Done/Error.
   initial begin : monitor
      int               driveCnt;
      logic [WIDTH-1:0] capS;
      logic [WIDTH-1:0] capR;
      entry_t           e;
      driveCnt = 0;
      capS     = '0;
      capR     = '0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            driveCnt = 0;
         end else begin
            if ((S | R) != '0) begin
               checkOutput("s_and_r_disjoint", S & R, 0);
               if (driveCnt == 0) begin
                  capS = S;
                  capR = R;
               end
               driveCnt++;
            end
            if (Done || Error) begin
               if (Done && Error) checkOutput("done_and_error", 1, 0);
               if (sbQ.size() == 0) begin
                  checkOutput("unexpected_completion", 1, 0);
               end else begin
                  e = sbQ.pop_front();
                  checkOutput("done_vs_error", Done, e.ok);
                  checkOutput("attempts", Attempts, e.att);
                  checkOutput("latency", cyc - e.acceptCycle, e.att * (2 + SETTLE_CYCLES));
                  checkOutput("drive_pulses", driveCnt, e.att);
                  if (e.att > 0) begin
                     checkOutput("first_s", capS, e.firstS);
                     checkOutput("first_r", capR, e.firstR);
                  end
                  if (e.ok) checkOutput("q_final", QFeedback, e.target);
               end
               driveCnt = 0;
            end
         end
      end
   end

   // Directed scenarios followed by randomized transactions.
   initial begin : stimulus
      logic [WIDTH-1:0] rq;
      logic [WIDTH-1:0] rs;
      logic [WIDTH-1:0] ri;
      logic [WIDTH-1:0] rt;
      Reset       = 1'b1;
      TargetValid = 1'b0;
      Target      = '0;
      presetReq   = 1'b0;
      presetQ     = '0;
      presetStuck = '0;
      presetIgn   = '0;
      flopQ       = '0;
      stuckMask   = '0;
      ignMask     = '0;
      #3;
      checkOutput("reset_ready", TargetReady, 0);
      checkOutput("reset_s", S, 0);
      checkOutput("reset_r", R, 0);
      checkOutput("reset_done", Done, 0);
      checkOutput("reset_error", Error, 0);
      checkOutput("reset_attempts", Attempts, 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      #1 checkOutput("ready_after_reset", TargetReady, 1);

      // Reset in the middle of a drive pulse abandons the transaction.
      setFlops(8'h00, 8'h00, 8'h00);
      applyStimulus(8'hFF);
      @(negedge Clock);
      checkOutput("mid_drive_s", S, 8'hFF);
      Reset = 1'b1;
      #1;
      checkOutput("async_reset_s", S, 0);
      checkOutput("async_reset_r", R, 0);
      checkOutput("async_reset_ready", TargetReady, 0);
      sbQ.delete();
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      #1 checkOutput("ready_after_abort", TargetReady, 1);
      repeat (6) @(negedge Clock);

      setFlops(8'h00, 8'h00, 8'h00);
      applyStimulus(8'hA5);
      drain();
      setFlops(8'hF0, 8'h00, 8'h00);
      applyStimulus(8'h0F);
      drain();
      setFlops(8'h3C, 8'h00, 8'h00);
      applyStimulus(8'h3C);
      drain();
      setFlops(8'h00, 8'h04, 8'h00);
      applyStimulus(8'h04);
      drain();
      setFlops(8'h00, 8'h00, 8'h01);
      applyStimulus(8'h01);
      drain();

      // Back-to-back: the second accept lands in the Done cycle of the first.
      setFlops(8'h00, 8'h00, 8'h00);
      applyStimulus(8'h5A);
      applyStimulus(8'hC3);
      applyStimulus(8'hC3);
      applyStimulus(8'h00);
      drain();

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0) begin
            drain();
            rq = WIDTH'($urandom);
            rs = ($urandom_range(2) == 0) ? WIDTH'(1 << $urandom_range(WIDTH - 1)) : '0;
            ri = WIDTH'($urandom) & WIDTH'($urandom);
            setFlops(rq, rs, ri);
         end
         rt = ($urandom_range(4) == 0) ? flopQ : WIDTH'($urandom);
         applyStimulus(rt);
         repeat ($urandom_range(2)) @(negedge Clock);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
